// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state type and
// the default operand width.
package iterative_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREP   = 2'd1,
    DIVIDE = 2'd2,
    FIX    = 2'd3
  } state_t;

endpackage

// File: rtl/iterative_divider_div_step.sv
// One combinational restoring-division step on unsigned magnitudes:
// shift {rem, quo} left, trial-subtract the divisor, keep the difference if it fits.
module div_step
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] kept;
  logic           borrow;
  logic           unused_kept_msb;

  assign shifted = {rem, quo[WIDTH-1]};

  // WIDTH+1-bit trial subtraction; the extra top bit is the borrow out
  assign {borrow, diff} = {1'b0, shifted} - {2'b00, dvs};

  // Whichever value is kept is below the divisor, so its top bit is always zero
  assign kept            = borrow ? shifted : diff;
  assign rem_next        = kept[WIDTH-1:0];
  assign unused_kept_msb = kept[WIDTH];

  assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle signed/unsigned integer divider (DIV/DIVU) with fixed latency:
// one restoring step per cycle, sign handling around an unsigned core.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    return cond_neg(v, sgn & v[WIDTH-1]);
  endfunction

  state_t           state;
  logic             is_signed_r;
  logic [WIDTH-1:0] dividend_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_mag;
  logic             q_neg;
  logic             r_neg;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .dvs      (dvs_mag),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      is_signed_r <= 1'b0;
      dividend_r  <= '0;
      divisor_r   <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvs_mag     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      count       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // Capture raw operands; later starts are ignored until back in IDLE
        IDLE: begin
          if (start) begin
            is_signed_r <= is_signed;
            dividend_r  <= dividend;
            divisor_r   <= divisor;
            state       <= PREP;
          end
        end
        // Convert to unsigned magnitudes and remember the result signs
        PREP: begin
          quo_r   <= magnitude(dividend_r, is_signed_r);
          dvs_mag <= magnitude(divisor_r, is_signed_r);
          rem_r   <= '0;
          q_neg   <= is_signed_r & (dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]);
          r_neg   <= is_signed_r & dividend_r[WIDTH-1];
          count   <= '0;
          state   <= DIVIDE;
        end
        // One quotient bit per cycle, MSB first
        DIVIDE: begin
          rem_r <= rem_next;
          quo_r <= quo_next;
          count <= count + CNT_W'(1);
          if (count == LAST_ITER) begin
            state <= FIX;
          end
        end
        // Restore signs; a zero divisor overrides with the fixed DIVU-style result
        FIX: begin
          if (divisor_r == '0) begin
            quotient    <= '1;
            remainder   <= dividend_r;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= cond_neg(quo_r, q_neg);
            remainder   <= cond_neg(rem_r, r_neg);
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed and randomized checks of iterative_divider against an arithmetic
// reference model (WIDTH = 32).
module tb_iterative_divider;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  iterative_divider #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the architectural corner cases
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    longint sa;
    longint sb;
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      z  = 1'b0;
    end
  endfunction

  // All tasks start and end at #1 after a rising edge
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 100);
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez);
    check({tag, "_done"}, W'(done), 1);
    check({tag, "_busy"}, W'(busy), 0);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, W'(div_by_zero), W'(ez));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez);
    int n;
    launch(a, b, s);
    check({tag, "_busy_flight"}, W'(busy), 1);
    wait_done(n);
    check({tag, "_latency"}, W'(n), W'(LAT));
    check_out(tag, eq, er, ez);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, W'(done), 0);
    check({tag, "_hold_q"}, quotient, eq);
    check({tag, "_hold_r"}, remainder, er);
  endtask

  initial begin
    logic [W-1:0] a, b, eq, er;
    logic         s, ez;
    int           n, seen;

    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", W'(div_by_zero), 0);
    rst = 1'b0;

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    run_op("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op("u_dz", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_op("s_dz", 32'h8765_4321, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    run_op("u_big", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Reset mid-operation: outputs clear, no done pulse, then normal service
    launch(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", W'(busy), 0);
    check("midrst_done", W'(done), 0);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_dbz", W'(div_by_zero), 0);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    check("midrst_nodone", W'(seen), 0);
    run_op("after_rst", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted
    launch(32'd500, 32'd9, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    dividend  = 32'd77;
    divisor   = 32'd5;
    is_signed = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check("b2b_first_lat", W'(n + 5), W'(LAT));
    check_out("b2b_first", 32'd55, 32'd5, 1'b0);
    launch(32'hFFFF_FF9C, 32'd7, 1'b1);
    check("b2b_second_busy", W'(busy), 1);
    wait_done(n);
    check("b2b_second_lat", W'(n), W'(LAT));
    check_out("b2b_second", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      int sel;
      a   = $urandom;
      sel = $urandom_range(0, 9);
      s   = 1'($urandom_range(0, 1));
      if (sel == 0) begin
        b = '0;
      end else if (sel < 5) begin
        b = W'($urandom_range(1, 100));
        if ($urandom_range(0, 1) == 1) b = -b;
      end else begin
        b = $urandom >> $urandom_range(0, 31);
      end
      model(a, b, s, eq, er, ez);
      run_op($sformatf("rnd%0d", i), a, b, s, eq, er, ez);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits; legal values are even and at least 4.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request; sampled only when busy=0.
REQ-005 Port: is_signed  input  1  1 = two's-complement DIV, 0 = DIVU; captured with start.
REQ-006 Port: dividend  input  WIDTH  numerator; captured with start.
REQ-007 Port: divisor  input  WIDTH  denominator; captured with start.
REQ-008 Port: busy  output  1  high while an operation is in flight.
REQ-009 Port: done  output  1  single-cycle pulse; results valid.
REQ-010 Port: quotient  output  WIDTH  result, LO destination.
REQ-011 Port: remainder  output  WIDTH  result, HI destination.
REQ-012 Port: div_by_zero  output  1  flag; valid with done and held until the next done.

Function
REQ-013 FSM states SHALL be IDLE, PREP, DIVIDE and FIX, with transitions IDLE->PREP on start, PREP->DIVIDE, DIVIDE->FIX after WIDTH iterations, and FIX->IDLE.
REQ-014 PREP SHALL register the operand magnitudes, which are absolute values when is_signed=1, and the result signs: quotient sign = sign(dividend) XOR sign(divisor), and remainder sign = sign(dividend).
REQ-015 DIVIDE SHALL perform one restoring step per cycle: shift left the {partial remainder, quotient} register, trial-subtract the divisor magnitude on WIDTH+1 bits, keep the difference if it is non-negative, and set the quotient LSB to NOT borrow.
REQ-016 FIX SHALL negate the quotient and remainder per the PREP signs, then register quotient, remainder and div_by_zero and assert done.
REQ-017 Latency SHALL be fixed: done is high in the cycle following the (WIDTH+2)th rising edge after the edge that samples start, which is 34 edges for WIDTH=32.
REQ-018 busy SHALL be high in PREP, DIVIDE and FIX, and low in IDLE, including the done cycle.
REQ-019 A start asserted in the done cycle SHALL be accepted, giving back-to-back operation with no bubble.
REQ-020 A start asserted while busy=1 SHALL be ignored, and operands captured earlier SHALL be unaffected.
REQ-021 quotient and remainder SHALL hold their values after done until the next done.
REQ-022 If divisor=0, the block SHALL still run the full latency and then return quotient = all ones, remainder = dividend (unmodified) and div_by_zero=1; these values are independent of is_signed.
REQ-023 For signed overflow (dividend = most negative value, divisor = -1), the block SHALL return quotient = most negative value, remainder = 0 and div_by_zero=0.
REQ-024 A non-zero remainder SHALL take the sign of the dividend, and the quotient SHALL truncate toward zero.
REQ-025 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL have no wrap-around within a single operation.

Reset
REQ-026 When rst=1 at a rising edge, the FSM SHALL go to IDLE, and busy, done, quotient, remainder, div_by_zero and all internal registers SHALL be set to 0.
REQ-027 If rst is asserted mid-operation, the operation SHALL be abandoned with no done pulse.
REQ-028 When rst and start are both high at the same edge, rst SHALL take priority and start SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the FSM state enum type and the default WIDTH constant.
REQ-030 One sub-module, div_step, SHALL implement a single combinational restoring step (shift, trial subtract, select) and be instantiated once.
REQ-031 The sign-handling and negation logic SHALL reside in iterative_divider.

Verification
REQ-032 Unsigned 100 / 7 -> quotient=14, remainder=2, div_by_zero=0, and done exactly 34 edges after start.
REQ-033 Signed -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-034 Divisor 0 with dividend 0x12345678 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, same latency.
REQ-035 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-036 rst asserted 10 cycles after start -> no done pulse, all outputs 0 at the next edge, and a new start completes normally.
REQ-037 Second start pulsed mid-operation, then a start in the done cycle -> the first result is unaffected and the second result arrives 34 edges after the done cycle.
